// File: rtl/gat_load_ctrl.sv
// Host-side load/run sequencer for the GAT accelerator: routes one host word stream into
// H-data, node-info and weight BRAM writes, then waits for gat_ready. Option: GAT_LOAD_CTRL_TIMEOUT_EN.
module gat_load_ctrl #(
  parameter int unsigned H_DATA_WIDTH    = 19,
  parameter int unsigned NODE_INFO_WIDTH = 20,
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned H_DATA_DEPTH    = 242101,
  parameter int unsigned NODE_INFO_DEPTH = 13264,
  parameter int unsigned WEIGHT_DEPTH    = 22928,
  parameter int unsigned TIMEOUT_CYCLES  = 32'd16777216
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 cmd_start,
  input  logic                                 cmd_layer,
  input  logic                                 cmd_reload_wgt,
  input  logic [31:0]                          s_data,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  output logic [H_DATA_WIDTH-1:0]              h_data_bram_din,
  output logic                                 h_data_bram_ena,
  output logic                                 h_data_bram_wea,
  output logic [$clog2(H_DATA_DEPTH)+1:0]      h_data_bram_addra,
  output logic [NODE_INFO_WIDTH-1:0]           h_node_info_bram_din,
  output logic                                 h_node_info_bram_ena,
  output logic                                 h_node_info_bram_wea,
  output logic [$clog2(NODE_INFO_DEPTH)+1:0]   h_node_info_bram_addra,
  output logic [DATA_WIDTH-1:0]                wgt_bram_din,
  output logic                                 wgt_bram_ena,
  output logic                                 wgt_bram_wea,
  output logic [$clog2(WEIGHT_DEPTH)+1:0]      wgt_bram_addra,
  output logic                                 h_data_bram_load_done,
  output logic                                 h_node_info_bram_load_done,
  output logic                                 wgt_bram_load_done,
  output logic                                 gat_layer,
  input  logic                                 gat_ready,
  output logic                                 busy,
  output logic                                 done,
  output logic [3:0]                           status
);

  localparam int unsigned HA_W  = $clog2(H_DATA_DEPTH);
  localparam int unsigned NA_W  = $clog2(NODE_INFO_DEPTH);
  localparam int unsigned WA_W  = $clog2(WEIGHT_DEPTH);
  localparam int unsigned HN_W  = (HA_W > NA_W) ? HA_W : NA_W;
  localparam int unsigned CNT_W = (HN_W > WA_W) ? HN_W : WA_W;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD_H  = 3'd1,
    S_LOAD_NI = 3'd2,
    S_LOAD_W  = 3'd3,
    S_RUN     = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  state_t state, next_state;

  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       reload_q, reload_d;
  logic                       ready_q, ready_prev_q, ready_prev_d;
  logic                       start_ok, accept, region_last, ready_rise, run_exit;
  logic                       timeout_nx;

  logic [H_DATA_WIDTH-1:0]    h_din_d;
  logic [HA_W+1:0]            h_addr_d;
  logic                       h_en_d;
  logic [NODE_INFO_WIDTH-1:0] ni_din_d;
  logic [NA_W+1:0]            ni_addr_d;
  logic                       ni_en_d;
  logic [DATA_WIDTH-1:0]      w_din_d;
  logic [WA_W+1:0]            w_addr_d;
  logic                       w_en_d;
  logic                       h_done_d, ni_done_d, w_done_d;
  logic                       layer_d, s_ready_d, busy_d, done_d;
  logic [3:0]                 status_d;

  // Two-bit state summary reported on status[1:0]: idle, loading, running, done.
  function automatic logic [1:0] state_summary(input state_t s);
    case (s)
      S_IDLE:  state_summary = 2'd0;
      S_RUN:   state_summary = 2'd2;
      S_DONE:  state_summary = 2'd3;
      default: state_summary = 2'd1;
    endcase
  endfunction

  assign start_ok   = cmd_start && ((state == S_IDLE) || (state == S_DONE));
  assign accept     = s_valid && s_ready;
  assign ready_rise = ready_q && !ready_prev_q;

  always_comb begin
    region_last = 1'b0;
    case (state)
      S_LOAD_H:  region_last = (cnt_q == CNT_W'(H_DATA_DEPTH - 1));
      S_LOAD_NI: region_last = (cnt_q == CNT_W'(NODE_INFO_DEPTH - 1));
      S_LOAD_W:  region_last = (cnt_q == CNT_W'(WEIGHT_DEPTH - 1));
      default:   region_last = 1'b0;
    endcase
  end

`ifdef GAT_LOAD_CTRL_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TO_W-1:0] wdog_q, wdog_d;
  logic            timeout_q, timeout_d, wdog_hit;
  logic            unused_bits;

  assign wdog_hit    = (state == S_RUN) && (wdog_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign run_exit    = ready_rise || wdog_hit;
  assign timeout_nx  = timeout_d;
  assign unused_bits = ^s_data;

  // Watchdog counts RUN cycles from zero; sticky timeout flag clears on the next start.
  always_comb begin
    wdog_d    = (state == S_RUN) ? wdog_q + TO_W'(1) : '0;
    timeout_d = timeout_q;
    if (start_ok)      timeout_d = 1'b0;
    else if (wdog_hit) timeout_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end
`else
  logic unused_bits;

  assign run_exit    = ready_rise;
  assign timeout_nx  = 1'b0;
  assign unused_bits = ^{s_data, TIMEOUT_CYCLES};
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE, S_DONE: if (cmd_start) next_state = S_LOAD_H;
      S_LOAD_H:       if (accept && region_last) next_state = S_LOAD_NI;
      S_LOAD_NI:      if (accept && region_last) next_state = reload_q ? S_LOAD_W : S_RUN;
      S_LOAD_W:       if (accept && region_last) next_state = S_RUN;
      S_RUN:          if (run_exit) next_state = S_DONE;
      default:        next_state = S_IDLE;
    endcase
  end

  // Next values of every registered output and of the datapath state.
  always_comb begin
    cnt_d        = cnt_q;
    reload_d     = reload_q;
    layer_d      = gat_layer;
    h_din_d      = h_data_bram_din;
    h_addr_d     = h_data_bram_addra;
    h_en_d       = 1'b0;
    ni_din_d     = h_node_info_bram_din;
    ni_addr_d    = h_node_info_bram_addra;
    ni_en_d      = 1'b0;
    w_din_d      = wgt_bram_din;
    w_addr_d     = wgt_bram_addra;
    w_en_d       = 1'b0;
    h_done_d     = h_data_bram_load_done;
    ni_done_d    = h_node_info_bram_load_done;
    w_done_d     = wgt_bram_load_done;
    ready_prev_d = ready_q;

    // A level that is already high when RUN is entered must drop before it counts.
    if ((state != S_RUN) && (next_state == S_RUN)) ready_prev_d = 1'b1;

    if (start_ok) begin
      cnt_d     = '0;
      reload_d  = cmd_reload_wgt;
      layer_d   = cmd_layer;
      h_done_d  = 1'b0;
      ni_done_d = 1'b0;
      if (cmd_reload_wgt) w_done_d = 1'b0;
    end

    if (accept) begin
      cnt_d = region_last ? '0 : cnt_q + CNT_W'(1);
      case (state)
        S_LOAD_H: begin
          h_en_d   = 1'b1;
          h_din_d  = s_data[H_DATA_WIDTH-1:0];
          h_addr_d = {cnt_q[HA_W-1:0], 2'b00};
          if (region_last) h_done_d = 1'b1;
        end
        S_LOAD_NI: begin
          ni_en_d   = 1'b1;
          ni_din_d  = s_data[NODE_INFO_WIDTH-1:0];
          ni_addr_d = {cnt_q[NA_W-1:0], 2'b00};
          if (region_last) ni_done_d = 1'b1;
        end
        S_LOAD_W: begin
          w_en_d   = 1'b1;
          w_din_d  = s_data[DATA_WIDTH-1:0];
          w_addr_d = {cnt_q[WA_W-1:0], 2'b00};
          if (region_last) w_done_d = 1'b1;
        end
        default: ;
      endcase
    end

    s_ready_d = (next_state == S_LOAD_H) || (next_state == S_LOAD_NI) ||
                (next_state == S_LOAD_W);
    busy_d    = (next_state != S_IDLE) && (next_state != S_DONE);
    done_d    = (state == S_RUN) && (next_state == S_DONE);
    status_d  = {timeout_nx, 1'b0, state_summary(next_state)};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q                      <= '0;
      reload_q                   <= 1'b1;
      ready_q                    <= 1'b0;
      ready_prev_q               <= 1'b0;
      gat_layer                  <= 1'b0;
      s_ready                    <= 1'b0;
      busy                       <= 1'b0;
      done                       <= 1'b0;
      status                     <= '0;
      h_data_bram_din            <= '0;
      h_data_bram_addra          <= '0;
      h_data_bram_ena            <= 1'b0;
      h_data_bram_wea            <= 1'b0;
      h_node_info_bram_din       <= '0;
      h_node_info_bram_addra     <= '0;
      h_node_info_bram_ena       <= 1'b0;
      h_node_info_bram_wea       <= 1'b0;
      wgt_bram_din               <= '0;
      wgt_bram_addra             <= '0;
      wgt_bram_ena               <= 1'b0;
      wgt_bram_wea               <= 1'b0;
      h_data_bram_load_done      <= 1'b0;
      h_node_info_bram_load_done <= 1'b0;
      wgt_bram_load_done         <= 1'b0;
    end else begin
      cnt_q                      <= cnt_d;
      reload_q                   <= reload_d;
      ready_q                    <= gat_ready;
      ready_prev_q               <= ready_prev_d;
      gat_layer                  <= layer_d;
      s_ready                    <= s_ready_d;
      busy                       <= busy_d;
      done                       <= done_d;
      status                     <= status_d;
      h_data_bram_din            <= h_din_d;
      h_data_bram_addra          <= h_addr_d;
      h_data_bram_ena            <= h_en_d;
      h_data_bram_wea            <= h_en_d;
      h_node_info_bram_din       <= ni_din_d;
      h_node_info_bram_addra     <= ni_addr_d;
      h_node_info_bram_ena       <= ni_en_d;
      h_node_info_bram_wea       <= ni_en_d;
      wgt_bram_din               <= w_din_d;
      wgt_bram_addra             <= w_addr_d;
      wgt_bram_ena               <= w_en_d;
      wgt_bram_wea               <= w_en_d;
      h_data_bram_load_done      <= h_done_d;
      h_node_info_bram_load_done <= ni_done_d;
      wgt_bram_load_done         <= w_done_d;
    end
  end

endmodule

// File: tb/tb_gat_load_ctrl.sv
// Directed bench for gat_load_ctrl with small region depths (4/3/2) and a 16-cycle watchdog.
module tb_gat_load_ctrl;

  localparam int unsigned HW = 19;
  localparam int unsigned NW = 20;
  localparam int unsigned DW = 8;
  localparam int unsigned HD = 4;
  localparam int unsigned ND = 3;
  localparam int unsigned WD = 2;
  localparam int unsigned TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_start, cmd_layer, cmd_reload_wgt;
  logic [31:0]   s_data;
  logic          s_valid, s_ready;
  logic [HW-1:0] h_din;
  logic          h_ena, h_wea;
  logic [3:0]    h_addra;
  logic [NW-1:0] ni_din;
  logic          ni_ena, ni_wea;
  logic [3:0]    ni_addra;
  logic [DW-1:0] w_din;
  logic          w_ena, w_wea;
  logic [2:0]    w_addra;
  logic          h_done, ni_done, w_done;
  logic          gat_layer, gat_ready, busy, done;
  logic [3:0]    status;

  gat_load_ctrl #(
    .H_DATA_WIDTH(HW), .NODE_INFO_WIDTH(NW), .DATA_WIDTH(DW),
    .H_DATA_DEPTH(HD), .NODE_INFO_DEPTH(ND), .WEIGHT_DEPTH(WD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_start(cmd_start), .cmd_layer(cmd_layer), .cmd_reload_wgt(cmd_reload_wgt),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .h_data_bram_din(h_din), .h_data_bram_ena(h_ena), .h_data_bram_wea(h_wea),
    .h_data_bram_addra(h_addra),
    .h_node_info_bram_din(ni_din), .h_node_info_bram_ena(ni_ena),
    .h_node_info_bram_wea(ni_wea), .h_node_info_bram_addra(ni_addra),
    .wgt_bram_din(w_din), .wgt_bram_ena(w_ena), .wgt_bram_wea(w_wea),
    .wgt_bram_addra(w_addra),
    .h_data_bram_load_done(h_done), .h_node_info_bram_load_done(ni_done),
    .wgt_bram_load_done(w_done),
    .gat_layer(gat_layer), .gat_ready(gat_ready),
    .busy(busy), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  typedef struct {
    int region;
    int addr;
    int din;
    int we;
    int cyc;
  } wr_t;

  int  n_cmp = 0;
  int  n_err = 0;
  int  cyc = 0;
  wr_t wr_q[$];
  int  h_rise, ni_rise, w_rise;
  int  done_cnt = 0;
  logic h_prev = 1'b0, ni_prev = 1'b0, w_prev = 1'b0;

  // Expected region/byte address for each beat of a full 4+3+2 load.
  int exp_region [9] = '{0, 0, 0, 0, 1, 1, 1, 2, 2};
  int exp_addr   [9] = '{0, 4, 8, 12, 0, 4, 8, 0, 4};

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every visible BRAM write, load-done rise and done pulse.
  always @(negedge clk) begin
    wr_t w;
    if (h_ena) begin
      w.region = 0; w.addr = int'(h_addra); w.din = int'(h_din); w.we = int'(h_wea); w.cyc = cyc;
      wr_q.push_back(w);
    end
    if (ni_ena) begin
      w.region = 1; w.addr = int'(ni_addra); w.din = int'(ni_din); w.we = int'(ni_wea); w.cyc = cyc;
      wr_q.push_back(w);
    end
    if (w_ena) begin
      w.region = 2; w.addr = int'(w_addra); w.din = int'(w_din); w.we = int'(w_wea); w.cyc = cyc;
      wr_q.push_back(w);
    end
    if (h_done && !h_prev)   h_rise  = cyc;
    if (ni_done && !ni_prev) ni_rise = cyc;
    if (w_done && !w_prev)   w_rise  = cyc;
    h_prev  = h_done;
    ni_prev = ni_done;
    w_prev  = w_done;
    if (done) done_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_mon();
    wr_q.delete();
    h_rise  = -1;
    ni_rise = -1;
    w_rise  = -1;
  endtask

  task automatic do_start(input logic layer, input logic reload);
    cmd_layer      = layer;
    cmd_reload_wgt = reload;
    cmd_start      = 1'b1;
    @(negedge clk);
    cmd_start      = 1'b0;
  endtask

  // Offer n beats first, first+1, ...; with gap, s_valid drops every other cycle.
  task automatic stream(input string tag, input int n, input int first, input bit gap);
    int i = 0;
    int guard = 0;
    while (i < n && guard < 100) begin
      s_valid = 1'b1;
      s_data  = 32'(first + i);
      if (s_ready) i++;
      @(negedge clk);
      guard++;
      if (gap) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
    end
    s_valid = 1'b0;
    check({tag, ".beats"}, i, n);
  endtask

  task automatic check_load(input string tag, input int base, input int n);
    #1;
    check({tag, ".nwr"}, wr_q.size(), n);
    for (int k = 0; k < n && k < wr_q.size(); k++) begin
      check($sformatf("%s.region%0d", tag, k), wr_q[k].region, exp_region[k]);
      check($sformatf("%s.addr%0d", tag, k), wr_q[k].addr, exp_addr[k]);
      check($sformatf("%s.din%0d", tag, k), wr_q[k].din, base + k);
      check($sformatf("%s.we%0d", tag, k), wr_q[k].we, 1);
    end
  endtask

  task automatic pulse_ready_and_check(input string tag);
    gat_ready = 1'b0;
    tick(2);
    gat_ready = 1'b1;
    tick(1);
    check({tag, ".done_early"}, done, 0);
    tick(1);
    check({tag, ".done"}, done, 1);
    check({tag, ".busy"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    rst = 1'b1; cmd_start = 1'b0; cmd_layer = 1'b0; cmd_reload_wgt = 1'b0;
    s_data = '0; s_valid = 1'b0; gat_ready = 1'b0;
    tick(2);
    check("rst.ctrl", {s_ready, busy, done, gat_layer, h_done, ni_done, w_done}, 0);
    check("rst.status", status, 0);
    check("rst.ena", {h_ena, ni_ena, w_ena}, 0);
    rst = 1'b0;
    tick(1);
    check("idle.busy", busy, 0);

    // Full load with weights, continuous valid
    #1 clear_mon();
    do_start(1'b1, 1'b1);
    check("full.s_ready_on", s_ready, 1);
    check("full.busy_on", busy, 1);
    check("full.layer", gat_layer, 1);
    stream("full", 9, 1, 1'b0);
    check("full.s_ready_off", s_ready, 0);
    check("full.busy_run", busy, 1);
    check("full.flags", {h_done, ni_done, w_done}, 3'b111);
    check_load("full", 1, 9);
    if (wr_q.size() == 9) begin
      check("full.h_rise", h_rise, wr_q[3].cyc);
      check("full.ni_rise", ni_rise, wr_q[6].cyc);
      check("full.w_rise", w_rise, wr_q[8].cyc);
      check("full.burst", wr_q[8].cyc - wr_q[0].cyc, 8);
    end

    // Run: ready low for 5 RUN cycles, then rise; done 2 cycles later
    tick(4);
    check("run.done_wait", done, 0);
    check("run.busy_wait", busy, 1);
    gat_ready = 1'b1;
    tick(1);
    check("run.done_1", done, 0);
    tick(1);
    check("run.done_2", done, 1);
    check("run.busy_off", busy, 0);
    check("run.timeout_bit", status[3], 0);
    tick(1);
    check("run.done_pulse", done, 0);
    check("run.flags_hold", {h_done, ni_done, w_done}, 3'b111);
    check("run.layer_hold", gat_layer, 1);
    #1 check("run.done_cnt", done_cnt, 1);

    // Weight skip, started from DONE with gat_ready still high
    clear_mon();
    do_start(1'b0, 1'b0);
    check("skip.flags_start", {h_done, ni_done, w_done}, 3'b001);
    check("skip.layer", gat_layer, 0);
    stream("skip", 7, 'h21, 1'b0);
    check("skip.s_ready_off", s_ready, 0);
    check("skip.flags", {h_done, ni_done, w_done}, 3'b111);
    check_load("skip", 'h21, 7);
    tick(4);
    check("skip.stale_ready", done, 0);
    check("skip.busy_run", busy, 1);
    pulse_ready_and_check("skip");
    #1 check("skip.done_cnt", done_cnt, 2);

    // Backpressure: valid every other cycle
    clear_mon();
    do_start(1'b1, 1'b1);
    check("bp.w_done_clr", w_done, 0);
    stream("bp", 9, 'h31, 1'b1);
    check("bp.s_ready_off", s_ready, 0);
    check_load("bp", 'h31, 9);
    if (wr_q.size() == 9) check("bp.spacing", wr_q[8].cyc - wr_q[0].cyc, 16);
    pulse_ready_and_check("bp");

    // Reset in the middle of a load
    #1 clear_mon();
    do_start(1'b1, 1'b1);
    stream("mid", 5, 'h51, 1'b0);
    rst = 1'b1;
    #1;
    check("mid.ctrl", {s_ready, busy, done, gat_layer, h_done, ni_done, w_done}, 0);
    check("mid.status", status, 0);
    check("mid.ena", {h_ena, h_wea, ni_ena, ni_wea, w_ena, w_wea}, 0);
    check("mid.addr", {h_addra, ni_addra, w_addra}, 0);
    check("mid.din", {h_din, ni_din, w_din}, 0);
    tick(1);
    rst = 1'b0;
    tick(1);
    #1 clear_mon();
    do_start(1'b0, 1'b1);
    stream("mid2", 9, 'h61, 1'b0);
    check_load("mid2", 'h61, 9);
    pulse_ready_and_check("mid2");

`ifdef GAT_LOAD_CTRL_TIMEOUT_EN
    // Watchdog: RUN with ready held low ends after 16 cycles
    gat_ready = 1'b0;
    #1 clear_mon();
    do_start(1'b0, 1'b1);
    stream("to", 9, 'h71, 1'b0);
    tick(15);
    check("to.done_early", done, 0);
    check("to.bit_early", status[3], 0);
    tick(1);
    check("to.done", done, 1);
    check("to.bit", status[3], 1);
    check("to.busy", busy, 0);
    do_start(1'b1, 1'b1);
    check("to.bit_clr", status[3], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
